pixel_readout_serializer: RTL and testbench

Next-generation pixel-array readout bus. It accepts one full row of Gray-coded pixel words per handshake and serialises it into beats of OUTPUT_BUS_PIXEL_WIDTH pixels each. Per row it can optionally Gray-decode to binary, and it tags each beat with row/frame framing flags. It sits between the pixel array's row latch and the downstream output bus, with valid/ready flow control on both sides.

---
 rtl/pixel_bus_pkg.sv | 16 +
 rtl/gray_to_binary.sv | 22 ++
 rtl/pixel_readout_serializer.sv | 142 ++++++++++++++
 tb/tb_pixel_readout_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_pkg.sv
// Shared constants and beat framing types for the pixel readout bus.
// Defaults match the reference array geometry.
package pixel_bus_pkg;

    localparam int DEF_BIT_DEPTH  = 8;
    localparam int DEF_WIDTH      = 4;
    localparam int DEF_BUS_PIXELS = 2;
    localparam int DEF_HEIGHT     = 2;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } beat_flags_t;

endpackage

// File: rtl/gray_to_binary.sv
// Per-pixel Gray-to-binary decoder with a pass-through bypass.
// Binary bit i is the XOR of all Gray bits from i up to the MSB.
module gray_to_binary #(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0] gray,
    input  logic                 bypass,
    output logic [BIT_DEPTH-1:0] bin
);

    logic [BIT_DEPTH-1:0] dec;

    always_comb begin
        dec = '0;
        for (int i = 0; i < BIT_DEPTH; i++) begin
            dec[i] = ^(gray >> i);
        end
    end

    assign bin = bypass ? gray : dec;

endmodule

// File: rtl/pixel_readout_serializer.sv
// Row-wide pixel latch to narrow output bus serializer with optional
// Gray decode and SOF/EOL/EOF framing flags.
module pixel_readout_serializer
    import pixel_bus_pkg::*;
#(
    parameter int BIT_DEPTH              = DEF_BIT_DEPTH,
    parameter int WIDTH                  = DEF_WIDTH,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = DEF_BUS_PIXELS,
    parameter int HEIGHT                 = DEF_HEIGHT
) (
    input  logic                                      CLK,
    input  logic                                      RESET_N,
    input  logic                                      CLEAR,
    input  logic [WIDTH*BIT_DEPTH-1:0]                ROW_DATA,
    input  logic                                      ROW_VALID,
    output logic                                      ROW_READY,
    input  logic                                      GRAY_EN,
    output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] OUT,
    output logic                                      OUT_VALID,
    input  logic                                      OUT_READY,
    output logic                                      OUT_SOF,
    output logic                                      OUT_EOL,
    output logic                                      OUT_EOF
);

    localparam int BEATS = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
    localparam int CHUNK = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
    localparam int ROW_W = WIDTH * BIT_DEPTH;
    localparam int BLW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RCW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    if ((WIDTH % OUTPUT_BUS_PIXEL_WIDTH) != 0 ||
        WIDTH < OUTPUT_BUS_PIXEL_WIDTH) begin : g_bad_width
        $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
    end
    if (HEIGHT < 1) begin : g_bad_height
        $error("HEIGHT must be at least 1");
    end

    logic [ROW_W-1:0] row_buf, row_buf_nxt;
    logic [BLW-1:0]   beats_left, beats_left_nxt;
    logic [RCW-1:0]   row_cnt, row_cnt_nxt, row_cnt_adv;
    logic             gray_flag, gray_flag_nxt;
    logic             out_valid, out_valid_nxt;
    logic [CHUNK-1:0] out_data, out_nxt;
    logic [CHUNK-1:0] chunk, decoded;
    beat_flags_t      flags, flags_nxt;
    logic             accept, beat_hs, last_beat, bypass;
    logic             row_ready;

    assign last_beat = (beats_left == '0);
    assign row_ready = !CLEAR && (!out_valid || (OUT_READY && last_beat));
    assign accept    = ROW_VALID && row_ready;
    assign beat_hs   = out_valid && OUT_READY;

    // A freshly accepted row feeds the decoders directly for zero latency.
    assign chunk  = accept ? ROW_DATA[CHUNK-1:0] : row_buf[CHUNK-1:0];
    assign bypass = accept ? !GRAY_EN : !gray_flag;

    for (genvar j = 0; j < OUTPUT_BUS_PIXEL_WIDTH; j++) begin : g_dec
        gray_to_binary #(
            .BIT_DEPTH(BIT_DEPTH)
        ) u_dec (
            .gray  (chunk[j*BIT_DEPTH +: BIT_DEPTH]),
            .bypass(bypass),
            .bin   (decoded[j*BIT_DEPTH +: BIT_DEPTH])
        );
    end

    assign row_cnt_adv = (row_cnt == RCW'(HEIGHT-1)) ? '0
                                                     : row_cnt + RCW'(1);

    always_comb begin
        row_buf_nxt    = row_buf;
        beats_left_nxt = beats_left;
        row_cnt_nxt    = row_cnt;
        gray_flag_nxt  = gray_flag;
        out_valid_nxt  = out_valid;
        out_nxt        = out_data;
        flags_nxt      = flags;
        if (CLEAR) begin
            out_valid_nxt  = 1'b0;
            flags_nxt      = '0;
            beats_left_nxt = '0;
            row_cnt_nxt    = '0;
        end else begin
            if (beat_hs && last_beat) begin
                row_cnt_nxt = row_cnt_adv;
            end
            if (accept) begin
                out_nxt        = decoded;
                out_valid_nxt  = 1'b1;
                row_buf_nxt    = ROW_DATA >> CHUNK;
                beats_left_nxt = BLW'(BEATS-1);
                gray_flag_nxt  = GRAY_EN;
                flags_nxt.sof  = (row_cnt_nxt == '0);
                flags_nxt.eol  = (BEATS == 1);
                flags_nxt.eof  = (BEATS == 1) &&
                                 (row_cnt_nxt == RCW'(HEIGHT-1));
            end else if (beat_hs && !last_beat) begin
                out_nxt        = decoded;
                row_buf_nxt    = row_buf >> CHUNK;
                beats_left_nxt = beats_left - BLW'(1);
                flags_nxt.sof  = 1'b0;
                flags_nxt.eol  = (beats_left == BLW'(1));
                flags_nxt.eof  = (beats_left == BLW'(1)) &&
                                 (row_cnt == RCW'(HEIGHT-1));
            end else if (beat_hs) begin
                out_valid_nxt = 1'b0;
                flags_nxt     = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_buf    <= '0;
            beats_left <= '0;
            row_cnt    <= '0;
            gray_flag  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            flags      <= '0;
        end else begin
            row_buf    <= row_buf_nxt;
            beats_left <= beats_left_nxt;
            row_cnt    <= row_cnt_nxt;
            gray_flag  <= gray_flag_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_nxt;
            flags      <= flags_nxt;
        end
    end

    assign ROW_READY = row_ready;
    assign OUT       = out_data;
    assign OUT_VALID = out_valid;
    assign OUT_SOF   = flags.sof;
    assign OUT_EOL   = flags.eol;
    assign OUT_EOF   = flags.eof;

endmodule

// File: tb/tb_pixel_readout_serializer.sv
// Directed bench for the pixel readout serializer at default geometry
// (8-bit pixels, 4-pixel rows, 2-pixel beats, 2-row frames).
module tb_pixel_readout_serializer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CLEAR;
    logic [31:0] ROW_DATA;
    logic        ROW_VALID;
    logic        ROW_READY;
    logic        GRAY_EN;
    logic [15:0] OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_SOF;
    logic        OUT_EOL;
    logic        OUT_EOF;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ROW_G = 32'h0301_8007;
    localparam logic [31:0] ROW_A = 32'h4433_2211;
    localparam logic [31:0] ROW_B = 32'h8877_6655;

    pixel_readout_serializer dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .CLEAR    (CLEAR),
        .ROW_DATA (ROW_DATA),
        .ROW_VALID(ROW_VALID),
        .ROW_READY(ROW_READY),
        .GRAY_EN  (GRAY_EN),
        .OUT      (OUT),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_SOF  (OUT_SOF),
        .OUT_EOL  (OUT_EOL),
        .OUT_EOF  (OUT_EOF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Beat check: data, valid and the three flags as one packed word.
    task automatic test_beat(input string name, input logic [15:0] d,
                             input logic [2:0] sef);
        total++;
        if (OUT_VALID !== 1'b1 || OUT !== d ||
            {OUT_SOF, OUT_EOL, OUT_EOF} !== sef) begin
            bad++;
            $display("FAIL %s: got valid=%b out=%h sof/eol/eof=%b want valid=1 out=%h sof/eol/eof=%b",
                     name, OUT_VALID, OUT, {OUT_SOF, OUT_EOL, OUT_EOF}, d, sef);
        end
    endtask

    task automatic test_idle(input string name);
        total++;
        if (OUT_VALID !== 1'b0 || {OUT_SOF, OUT_EOL, OUT_EOF} !== 3'b000) begin
            bad++;
            $display("FAIL %s: got valid=%b flags=%b want valid=0 flags=000",
                     name, OUT_VALID, {OUT_SOF, OUT_EOL, OUT_EOF});
        end
    endtask

    task automatic test_rdy(input string name, input logic exp);
        total++;
        if (ROW_READY !== exp) begin
            bad++;
            $display("FAIL %s: ROW_READY got %b want %b", name, ROW_READY, exp);
        end
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        CLEAR     = 1'b0;
        ROW_DATA  = '0;
        ROW_VALID = 1'b0;
        GRAY_EN   = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) tick();
        total++;
        if (OUT !== 16'h0 || OUT_VALID !== 1'b0 ||
            {OUT_SOF, OUT_EOL, OUT_EOF} !== 3'b000) begin
            bad++;
            $display("FAIL reset: got out=%h valid=%b flags=%b want all 0",
                     OUT, OUT_VALID, {OUT_SOF, OUT_EOL, OUT_EOF});
        end
        test_rdy("reset_ready", 1'b1);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_gray_decode();
        ROW_DATA  = ROW_G;
        GRAY_EN   = 1'b1;
        ROW_VALID = 1'b1;
        #1;
        test_rdy("gray_ready", 1'b1);
        tick();
        ROW_VALID = 1'b0;
        test_beat("gray_b0", 16'hFF05, 3'b100);
        tick();
        test_beat("gray_b1", 16'h0201, 3'b010);
        tick();
        test_idle("gray_end");
    endtask

    // Row counter is now 1, so this row is the frame's last.
    task automatic test_bypass();
        ROW_DATA  = ROW_G;
        GRAY_EN   = 1'b0;
        ROW_VALID = 1'b1;
        tick();
        ROW_VALID = 1'b0;
        test_beat("byp_b0", 16'h8007, 3'b000);
        tick();
        test_beat("byp_b1", 16'h0301, 3'b011);
        tick();
        test_idle("byp_end");
    endtask

    task automatic test_back_to_back();
        logic [31:0] rows [4];
        logic [15:0] exp  [8];
        rows = '{ROW_A, ROW_B, ROW_A, ROW_B};
        exp  = '{16'h2211, 16'h4433, 16'h6655, 16'h8877,
                 16'h2211, 16'h4433, 16'h6655, 16'h8877};
        GRAY_EN   = 1'b0;
        OUT_READY = 1'b1;
        ROW_DATA  = rows[0];
        ROW_VALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            test_beat($sformatf("b2b_beat%0d", i), exp[i],
                      {(i == 0 || i == 4), (i % 2 == 1), (i == 3 || i == 7)});
            test_rdy($sformatf("b2b_rdy%0d", i), (i % 2 == 1));
            if (i % 2 == 1) begin
                if ((i + 1) / 2 < 4) ROW_DATA = rows[(i + 1) / 2];
                else ROW_VALID = 1'b0;
            end
        end
        tick();
        test_idle("b2b_end");
    endtask

    task automatic test_clear();
        GRAY_EN   = 1'b0;
        ROW_DATA  = ROW_A;
        ROW_VALID = 1'b1;
        tick();
        test_beat("clr_b0", 16'h2211, 3'b100);
        ROW_DATA = ROW_B;
        CLEAR    = 1'b1;
        #1;
        test_rdy("clr_ready_low", 1'b0);
        tick();
        test_idle("clr_flush");
        CLEAR = 1'b0;
        #1;
        test_rdy("clr_ready_back", 1'b1);
        tick();
        ROW_VALID = 1'b0;
        test_beat("clr_row_b0", 16'h6655, 3'b100);
        tick();
        test_beat("clr_row_b1", 16'h8877, 3'b010);
        tick();
        test_idle("clr_end");
    endtask

    // Row counter is 1 here: beat 1 also carries EOF.
    task automatic test_backpressure();
        ROW_DATA  = ROW_G;
        GRAY_EN   = 1'b1;
        OUT_READY = 1'b0;
        ROW_VALID = 1'b1;
        tick();
        ROW_VALID = 1'b0;
        test_beat("bp_b0", 16'hFF05, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            test_beat($sformatf("bp_hold%0d", i), 16'hFF05, 3'b000);
            test_rdy($sformatf("bp_rdy%0d", i), 1'b0);
        end
        OUT_READY = 1'b1;
        #1;
        test_rdy("bp_rdy_release", 1'b0);
        tick();
        test_beat("bp_b1", 16'h0201, 3'b011);
        tick();
        test_idle("bp_end");
    endtask

    task automatic test_async_reset();
        GRAY_EN   = 1'b0;
        ROW_DATA  = ROW_A;
        ROW_VALID = 1'b1;
        tick();
        ROW_DATA = ROW_B;
        test_beat("ar_a0", 16'h2211, 3'b100);
        tick();
        test_beat("ar_a1", 16'h4433, 3'b010);
        tick();
        ROW_VALID = 1'b0;
        test_beat("ar_b0", 16'h6655, 3'b000);
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if (OUT !== 16'h0 || OUT_VALID !== 1'b0 ||
            {OUT_SOF, OUT_EOL, OUT_EOF} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: got out=%h valid=%b flags=%b want all 0",
                     OUT, OUT_VALID, {OUT_SOF, OUT_EOL, OUT_EOF});
        end
        @(negedge CLK);
        RESET_N   = 1'b1;
        ROW_DATA  = ROW_G;
        GRAY_EN   = 1'b1;
        ROW_VALID = 1'b1;
        tick();
        ROW_VALID = 1'b0;
        test_beat("ar_fresh_b0", 16'hFF05, 3'b100);
        tick();
        test_beat("ar_fresh_b1", 16'h0201, 3'b010);
        tick();
        test_idle("ar_end");
    endtask

    initial begin
        test_reset();
        test_gray_decode();
        test_bypass();
        test_back_to_back();
        test_clear();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
